i2s_rx_deserializer: RTL

I2S_RX_DESERIALIZER -- requirements
Module: i2s_rx_deserializer

---
 rtl/i2s_rx_deserializer_if.sv | 26 ++
 rtl/i2s_rx_deserializer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deserializer_if.sv
// I2S receive bundle: serial lines in, stereo sample pair with valid/ready out.
// master = deserializer side, slave = line driver / sample consumer side.
interface i2s_rx_deserializer_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic                           sck_i;
    logic                           ws_i;
    logic                           sd_i;
    logic signed [SAMPLE_WIDTH-1:0] left_o;
    logic signed [SAMPLE_WIDTH-1:0] right_o;
    logic                           valid_o;
    logic                           ready_i;
    logic                           frame_err_o;
    logic                           ovf_o;
    logic [15:0]                    ovf_cnt_o;

    modport master (
        input  sck_i, ws_i, sd_i, ready_i,
        output left_o, right_o, valid_o, frame_err_o, ovf_o, ovf_cnt_o
    );

    modport slave (
        output sck_i, ws_i, sd_i, ready_i,
        input  left_o, right_o, valid_o, frame_err_o, ovf_o, ovf_cnt_o
    );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: deserializes MSB-first stereo samples into a valid/ready pair; pair valid 1 clk after last right bit.
// A completed pair arriving while the held one is unaccepted is dropped (ovf). Macro I2S_RX_OVF_CNT_EN adds the drop counter.
module i2s_rx_deserializer #(
    parameter int   SAMPLE_WIDTH = 24,
    parameter int   SLOT_BITS    = 32,
    parameter logic WS_POL       = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    i2s_rx_deserializer_if.master bus
);
    typedef enum logic [1:0] {ST_SYNC, ST_LEFT, ST_RIGHT} state_e;

    localparam int             CW     = $clog2(SLOT_BITS + 1);
    localparam logic [CW-1:0]  SLOT_C = CW'(SLOT_BITS);
    localparam logic [CW-1:0]  SW_C   = CW'(SAMPLE_WIDTH);

    state_e                  state_q, state_d;
    logic                    sck_q, sck_d;
    logic                    ws_prev_q, ws_prev_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [SAMPLE_WIDTH-1:0] shl_q, shl_d;
    logic [SAMPLE_WIDTH-1:0] shr_q, shr_d;
    logic [SAMPLE_WIDTH-1:0] left_q, left_d;
    logic [SAMPLE_WIDTH-1:0] right_q, right_d;
    logic                    valid_q, valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    ovf_q, ovf_d;
    logic                    sck_rise, ws_edge, complete;

    always_comb begin
        state_d     = state_q;
        sck_d       = bus.sck_i;
        ws_prev_d   = ws_prev_q;
        cnt_d       = cnt_q;
        shl_d       = shl_q;
        shr_d       = shr_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        ovf_d       = 1'b0;
        complete    = 1'b0;

        sck_rise = bus.sck_i & ~sck_q;
        ws_edge  = sck_rise & (bus.ws_i != ws_prev_q);
        cnt_inc  = (cnt_q == SLOT_C) ? cnt_q : cnt_q + CW'(1);

        // WS history keeps tracking while disabled so re-enable sees a true edge
        if (sck_rise) begin
            ws_prev_d = bus.ws_i;
        end

        if (!en_i) begin
            state_d = ST_SYNC;
            cnt_d   = '0;
            shl_d   = '0;
            shr_d   = '0;
        end else if (ws_edge) begin
            // the edge rise carries the previous word's LSB (one-bit delay): no shift
            cnt_d = '0;
            case (state_q)
                ST_SYNC: begin
                    if (bus.ws_i == WS_POL) begin
                        state_d = ST_LEFT;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    if (cnt_q < SW_C) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_SYNC;
                    end else begin
                        state_d = (bus.ws_i == WS_POL) ? ST_LEFT : ST_RIGHT;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end else if (sck_rise) begin
            cnt_d = cnt_inc;
            if (cnt_inc <= SW_C) begin
                if (state_q == ST_LEFT) begin
                    shl_d = {shl_q[SAMPLE_WIDTH-2:0], bus.sd_i};
                end
                if (state_q == ST_RIGHT) begin
                    shr_d = {shr_q[SAMPLE_WIDTH-2:0], bus.sd_i};
                    complete = (cnt_inc == SW_C);
                end
            end
        end

        if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end

        if (complete) begin
            if (!valid_q || bus.ready_i) begin
                left_d  = shl_q;
                right_d = {shr_q[SAMPLE_WIDTH-2:0], bus.sd_i};
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_SYNC;
            sck_q       <= 1'b0;
            ws_prev_q   <= WS_POL;
            cnt_q       <= '0;
            shl_q       <= '0;
            shr_q       <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_q       <= sck_d;
            ws_prev_q   <= ws_prev_d;
            cnt_q       <= cnt_d;
            shl_q       <= shl_d;
            shr_q       <= shr_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef I2S_RX_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_d && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign bus.ovf_cnt_o = ovf_cnt_q;
`else
    assign bus.ovf_cnt_o = '0;
`endif

    assign bus.left_o      = left_q;
    assign bus.right_o     = right_q;
    assign bus.valid_o     = valid_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.ovf_o       = ovf_q;

endmodule
